// File: rtl/vscale_dp_hasti_sram_win_pkg.sv
// Shared HASTI widths, transfer/response codes, accelerator-window defaults
// and the p0 state encoding for the windowed dual-port SRAM.
package vscale_dp_hasti_sram_win_pkg;

  localparam int unsigned HASTI_BUS_WIDTH   = 32;
  localparam int unsigned HASTI_ADDR_WIDTH  = 32;
  localparam int unsigned HASTI_SIZE_WIDTH  = 3;
  localparam int unsigned HASTI_BURST_WIDTH = 3;
  localparam int unsigned HASTI_PROT_WIDTH  = 4;
  localparam int unsigned HASTI_TRANS_WIDTH = 2;

  typedef enum logic [1:0] {
    HASTI_TRANS_IDLE   = 2'd0,
    HASTI_TRANS_BUSY   = 2'd1,
    HASTI_TRANS_NONSEQ = 2'd2,
    HASTI_TRANS_SEQ    = 2'd3
  } hasti_trans_e;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  localparam int unsigned NWORDS_DEF     = 65536;
  localparam int unsigned WIN_TAG_HI_DEF = 31;
  localparam int unsigned WIN_TAG_LO_DEF = 18;
  localparam logic [13:0] WIN_TAG_DEF    = 14'h0001;
  localparam int unsigned WIN_RD_LAT_DEF = 1;
  localparam int unsigned ACC_AW_DEF     = 16;

  typedef enum logic [1:0] {
    P0_IDLE  = 2'd0,
    P0_WDATA = 2'd1,
    P0_RWAIT = 2'd2
  } p0_state_e;

  function automatic logic [3:0] size_lut(input logic [2:0] hsize);
    case (hsize)
      3'd0:    return 4'h1;
      3'd1:    return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/vscale_dp_hasti_sram_win_wmask.sv
// Byte and bit write masks for a HASTI transfer of the given size at the
// given byte offset within a 32-bit word.
module vscale_hasti_wmask
  import vscale_dp_hasti_sram_win_pkg::*;
(
  input  logic [2:0]  hsize,
  input  logic [1:0]  addr,
  output logic [3:0]  byte_mask,
  output logic [31:0] bit_mask
);

  always_comb begin
    byte_mask = size_lut(hsize) << addr;
    bit_mask  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end
  end

endmodule

// File: rtl/vscale_dp_hasti_sram_win.sv
// Dual-port HASTI SRAM (p0 data, p1 instruction) with an accelerator window
// on p0 that forwards tagged accesses to an external compute engine.
module vscale_dp_hasti_sram_win
  import vscale_dp_hasti_sram_win_pkg::*;
#(
  parameter int unsigned NWORDS     = NWORDS_DEF,
  parameter int unsigned WIN_TAG_HI = WIN_TAG_HI_DEF,
  parameter int unsigned WIN_TAG_LO = WIN_TAG_LO_DEF,
  parameter logic [WIN_TAG_HI-WIN_TAG_LO:0] WIN_TAG = WIN_TAG_DEF,
  parameter int unsigned WIN_RD_LAT = WIN_RD_LAT_DEF,
  parameter int unsigned ACC_AW     = ACC_AW_DEF
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [31:0]       p0_haddr,
  input  logic              p0_hwrite,
  input  logic [2:0]        p0_hsize,
  input  logic [2:0]        p0_hburst,
  input  logic              p0_hmastlock,
  input  logic [3:0]        p0_hprot,
  input  logic [1:0]        p0_htrans,
  input  logic [31:0]       p0_hwdata,
  output logic [31:0]       p0_hrdata,
  output logic              p0_hready,
  output logic              p0_hresp,
  input  logic [31:0]       p1_haddr,
  input  logic              p1_hwrite,
  input  logic [2:0]        p1_hsize,
  input  logic [2:0]        p1_hburst,
  input  logic              p1_hmastlock,
  input  logic [3:0]        p1_hprot,
  input  logic [1:0]        p1_htrans,
  input  logic [31:0]       p1_hwdata,
  output logic [31:0]       p1_hrdata,
  output logic              p1_hready,
  output logic              p1_hresp,
  output logic              acc_wren,
  output logic              acc_rden,
  output logic [ACC_AW-1:0] acc_addr,
  output logic [31:0]       acc_wrdata,
  output logic [3:0]        acc_wrbe,
  input  logic [31:0]       acc_rddata,
  input  logic              acc_done,
  output logic              acc_irq,
  input  logic              acc_irq_clr
);

  localparam int unsigned IDX_W    = $clog2(NWORDS);
  localparam logic [1:0]  CNT_LAST = (WIN_RD_LAT > 1) ? 2'(WIN_RD_LAT - 2) : 2'd0;

  p0_state_e   state;
  logic [31:0] wr_addr;
  logic [2:0]  wr_size;
  logic        wr_win;
  logic [1:0]  wait_cnt;
  logic        p0_rd_win;
  logic [31:0] p0_rd_q;
  logic [31:0] p1_rd_q;
  logic [31:0] mem [NWORDS];

  logic [3:0]       wr_byte_mask;
  logic [31:0]      wr_bit_mask;
  logic [IDX_W-1:0] wr_idx, p0_idx, p1_idx;
  logic             p0_win_hit, p1_win_hit;
  logic             commit, mem_commit, p0_byp, p1_byp;
  logic [31:0]      commit_word;

  vscale_hasti_wmask u_wmask (
    .hsize     (wr_size),
    .addr      (wr_addr[1:0]),
    .byte_mask (wr_byte_mask),
    .bit_mask  (wr_bit_mask)
  );

  assign wr_idx     = wr_addr[IDX_W+1:2];
  assign p0_idx     = p0_haddr[IDX_W+1:2];
  assign p1_idx     = p1_haddr[IDX_W+1:2];
  assign p0_win_hit = (p0_haddr[WIN_TAG_HI:WIN_TAG_LO] == WIN_TAG);
  assign p1_win_hit = (p1_haddr[WIN_TAG_HI:WIN_TAG_LO] == WIN_TAG);

  assign commit      = (state == P0_WDATA) && !hreset;
  assign mem_commit  = commit && !wr_win;
  assign commit_word = (p0_hwdata & wr_bit_mask) | (mem[wr_idx] & ~wr_bit_mask);
  // Reads are registered at the address phase, so a read of the word being
  // committed this cycle must take the merged value instead of the array.
  assign p0_byp = mem_commit && (p0_idx == wr_idx);
  assign p1_byp = mem_commit && (p1_idx == wr_idx);

  assign p0_hready = (state != P0_RWAIT);
  assign p0_hresp  = HASTI_RESP_OKAY;
  assign p1_hready = 1'b1;
  assign p1_hresp  = HASTI_RESP_OKAY;
  assign p0_hrdata = p0_rd_win ? acc_rddata : p0_rd_q;
  assign p1_hrdata = p1_rd_q;

  assign acc_rden   = !hreset && (state != P0_RWAIT) && (p0_htrans == HASTI_TRANS_NONSEQ)
                      && !p0_hwrite && p0_win_hit;
  assign acc_wren   = commit && wr_win;
  // A window write commit owns acc_addr over a same-cycle window read phase.
  assign acc_addr   = acc_wren ? wr_addr[ACC_AW+1:2] : p0_haddr[ACC_AW+1:2];
  assign acc_wrdata = p0_hwdata;
  assign acc_wrbe   = acc_wren ? wr_byte_mask : '0;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= P0_IDLE;
      wr_addr   <= '0;
      wr_size   <= '0;
      wr_win    <= 1'b0;
      wait_cnt  <= '0;
      p0_rd_win <= 1'b0;
      p0_rd_q   <= '0;
      p1_rd_q   <= '0;
    end else begin
      if (state == P0_RWAIT) begin
        if (wait_cnt == CNT_LAST) state <= P0_IDLE;
        else                      wait_cnt <= wait_cnt + 2'd1;
      end else if (p0_htrans == HASTI_TRANS_NONSEQ) begin
        if (p0_hwrite) begin
          state   <= P0_WDATA;
          wr_addr <= p0_haddr;
          wr_size <= p0_hsize;
          wr_win  <= p0_win_hit;
        end else if (p0_win_hit) begin
          state     <= (WIN_RD_LAT > 1) ? P0_RWAIT : P0_IDLE;
          wait_cnt  <= '0;
          p0_rd_win <= 1'b1;
        end else begin
          state     <= P0_IDLE;
          p0_rd_win <= 1'b0;
          p0_rd_q   <= p0_byp ? commit_word : mem[p0_idx];
        end
      end else begin
        state <= P0_IDLE;
      end

      if ((p1_htrans == HASTI_TRANS_NONSEQ) && !p1_hwrite) begin
        p1_rd_q <= p1_win_hit ? '0 : (p1_byp ? commit_word : mem[p1_idx]);
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (mem_commit) mem[wr_idx] <= commit_word;
  end

  always_ff @(posedge hclk) begin
    if (hreset)           acc_irq <= 1'b0;
    else if (acc_done)    acc_irq <= 1'b1;
    else if (acc_irq_clr) acc_irq <= 1'b0;
  end

  logic unused_sigs;
  assign unused_sigs = ^{p0_hburst, p0_hmastlock, p0_hprot, p1_hburst, p1_hmastlock,
                         p1_hprot, p1_hsize, p1_hwdata, p0_haddr, p1_haddr, wr_addr};

endmodule

// File: tb/tb_vscale_dp_hasti_sram_win.sv
// Directed bench: one instance with a 3-cycle window read latency, a second
// with zero wait states, both driven from the same bus stimulus.
module tb_vscale_dp_hasti_sram_win;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;

  logic        hclk, hreset;
  logic [31:0] p0_haddr, p0_hwdata, p1_haddr, p1_hwdata;
  logic        p0_hwrite, p1_hwrite, p0_hmastlock, p1_hmastlock;
  logic [2:0]  p0_hsize, p1_hsize, p0_hburst, p1_hburst;
  logic [3:0]  p0_hprot, p1_hprot;
  logic [1:0]  p0_htrans, p1_htrans;
  logic [31:0] acc_rddata;
  logic        acc_done, acc_irq_clr;

  logic [31:0] p0_hrdata, p1_hrdata, acc_wrdata;
  logic        p0_hready, p0_hresp, p1_hready, p1_hresp;
  logic        acc_wren, acc_rden, acc_irq;
  logic [15:0] acc_addr;
  logic [3:0]  acc_wrbe;

  logic [31:0] d1_p0_hrdata, d1_p1_hrdata, d1_acc_wrdata;
  logic        d1_p0_hready, d1_p0_hresp, d1_p1_hready, d1_p1_hresp;
  logic        d1_acc_wren, d1_acc_rden, d1_acc_irq;
  logic [15:0] d1_acc_addr;
  logic [3:0]  d1_acc_wrbe;

  int checks = 0;
  int failures = 0;

  vscale_dp_hasti_sram_win #(.NWORDS(4096), .WIN_RD_LAT(3)) u_dut (
    .hclk(hclk), .hreset(hreset),
    .p0_haddr(p0_haddr), .p0_hwrite(p0_hwrite), .p0_hsize(p0_hsize), .p0_hburst(p0_hburst),
    .p0_hmastlock(p0_hmastlock), .p0_hprot(p0_hprot), .p0_htrans(p0_htrans), .p0_hwdata(p0_hwdata),
    .p0_hrdata(p0_hrdata), .p0_hready(p0_hready), .p0_hresp(p0_hresp),
    .p1_haddr(p1_haddr), .p1_hwrite(p1_hwrite), .p1_hsize(p1_hsize), .p1_hburst(p1_hburst),
    .p1_hmastlock(p1_hmastlock), .p1_hprot(p1_hprot), .p1_htrans(p1_htrans), .p1_hwdata(p1_hwdata),
    .p1_hrdata(p1_hrdata), .p1_hready(p1_hready), .p1_hresp(p1_hresp),
    .acc_wren(acc_wren), .acc_rden(acc_rden), .acc_addr(acc_addr), .acc_wrdata(acc_wrdata),
    .acc_wrbe(acc_wrbe), .acc_rddata(acc_rddata), .acc_done(acc_done), .acc_irq(acc_irq),
    .acc_irq_clr(acc_irq_clr)
  );

  vscale_dp_hasti_sram_win #(.NWORDS(4096), .WIN_RD_LAT(1)) u_dut1 (
    .hclk(hclk), .hreset(hreset),
    .p0_haddr(p0_haddr), .p0_hwrite(p0_hwrite), .p0_hsize(p0_hsize), .p0_hburst(p0_hburst),
    .p0_hmastlock(p0_hmastlock), .p0_hprot(p0_hprot), .p0_htrans(p0_htrans), .p0_hwdata(p0_hwdata),
    .p0_hrdata(d1_p0_hrdata), .p0_hready(d1_p0_hready), .p0_hresp(d1_p0_hresp),
    .p1_haddr(p1_haddr), .p1_hwrite(p1_hwrite), .p1_hsize(p1_hsize), .p1_hburst(p1_hburst),
    .p1_hmastlock(p1_hmastlock), .p1_hprot(p1_hprot), .p1_htrans(p1_htrans), .p1_hwdata(p1_hwdata),
    .p1_hrdata(d1_p1_hrdata), .p1_hready(d1_p1_hready), .p1_hresp(d1_p1_hresp),
    .acc_wren(d1_acc_wren), .acc_rden(d1_acc_rden), .acc_addr(d1_acc_addr),
    .acc_wrdata(d1_acc_wrdata), .acc_wrbe(d1_acc_wrbe), .acc_rddata(acc_rddata),
    .acc_done(acc_done), .acc_irq(d1_acc_irq), .acc_irq_clr(acc_irq_clr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic p0_set(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz);
    p0_htrans = tr; p0_hwrite = wr; p0_haddr = a; p0_hsize = sz;
  endtask

  task automatic p1_set(input logic [1:0] tr, input logic [31:0] a);
    p1_htrans = tr; p1_hwrite = 1'b0; p1_haddr = a;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    repeat (3) tick();
    hreset = 1'b0;
    @(negedge hclk);
    checks++; if (p0_hready !== 1'b1) begin failures++; $display("FAIL rst_hready: got %b want 1", p0_hready); end
    checks++; if (acc_wren !== 1'b0) begin failures++; $display("FAIL rst_wren: got %b want 0", acc_wren); end
    checks++; if (acc_rden !== 1'b0) begin failures++; $display("FAIL rst_rden: got %b want 0", acc_rden); end
    checks++; if (acc_irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b want 0", acc_irq); end
    checks++; if (p0_hrdata !== 32'h0) begin failures++; $display("FAIL rst_p0_hrdata: got %h want 0", p0_hrdata); end
    checks++; if (p1_hrdata !== 32'h0) begin failures++; $display("FAIL rst_p1_hrdata: got %h want 0", p1_hrdata); end
    checks++; if (d1_p0_hrdata !== 32'h0) begin failures++; $display("FAIL rst_d1_hrdata: got %h want 0", d1_p0_hrdata); end
    checks++; if ({p1_hready, p0_hresp, p1_hresp} !== 3'b100) begin failures++; $display("FAIL rst_const: got %b want 100", {p1_hready, p0_hresp, p1_hresp}); end
    tick();
  endtask

  task automatic test_byte_write();
    p0_set(T_NONSEQ, 1'b1, 32'h1000, 3'd2); tick();
    p0_hwdata = 32'h11223344; p0_set(T_NONSEQ, 1'b1, 32'h1003, 3'd0); tick();
    p0_hwdata = 32'hAB000000; p0_set(T_NONSEQ, 1'b0, 32'h1000, 3'd2);
    @(negedge hclk);
    checks++; if (acc_wren !== 1'b0) begin failures++; $display("FAIL bw_no_wren: got %b want 0", acc_wren); end
    tick();
    p1_set(T_NONSEQ, 32'h1000);
    @(negedge hclk);
    checks++; if (p0_hrdata !== 32'hAB223344) begin failures++; $display("FAIL bw_p0_bypass: got %h want AB223344", p0_hrdata); end
    tick();
    p0_set(T_NONSEQ, 1'b1, 32'h1002, 3'd1); p1_set(T_IDLE, 32'h0);
    @(negedge hclk);
    checks++; if (p0_hrdata !== 32'hAB223344) begin failures++; $display("FAIL bw_p0_mem: got %h want AB223344", p0_hrdata); end
    checks++; if (p1_hrdata !== 32'hAB223344) begin failures++; $display("FAIL bw_p1_mem: got %h want AB223344", p1_hrdata); end
    tick();
    p0_hwdata = 32'h55660000; p0_set(T_IDLE, 1'b0, 32'h0, 3'd0); tick();
    p0_set(T_NONSEQ, 1'b0, 32'h1000, 3'd2); tick();
    p0_set(T_IDLE, 1'b0, 32'h0, 3'd0);
    @(negedge hclk);
    checks++; if (p0_hrdata !== 32'h55663344) begin failures++; $display("FAIL hw_write: got %h want 55663344", p0_hrdata); end
    tick();
  endtask

  task automatic test_bypass();
    p0_set(T_NONSEQ, 1'b1, 32'h2000, 3'd2); tick();
    p0_hwdata = 32'h12345678; p0_set(T_IDLE, 1'b0, 32'h0, 3'd0); tick();
    p0_set(T_NONSEQ, 1'b1, 32'h2000, 3'd2); tick();
    p0_hwdata = 32'hDEADBEEF; p0_set(T_IDLE, 1'b0, 32'h0, 3'd0); p1_set(T_NONSEQ, 32'h2000); tick();
    p1_set(T_NONSEQ, 32'h00040010);
    @(negedge hclk);
    checks++; if (p1_hrdata !== 32'hDEADBEEF) begin failures++; $display("FAIL p1_bypass: got %h want DEADBEEF", p1_hrdata); end
    tick();
    p1_set(T_NONSEQ, 32'h2000);
    @(negedge hclk);
    checks++; if (p1_hrdata !== 32'h0) begin failures++; $display("FAIL p1_window_zero: got %h want 0", p1_hrdata); end
    tick();
    p1_set(T_IDLE, 32'h0);
    @(negedge hclk);
    checks++; if (p1_hrdata !== 32'hDEADBEEF) begin failures++; $display("FAIL p1_mem_after: got %h want DEADBEEF", p1_hrdata); end
    tick();
  endtask

  task automatic test_window_write();
    p0_set(T_NONSEQ, 1'b1, 32'h10, 3'd2); tick();
    p0_hwdata = 32'h0A0B0C0D; p0_set(T_NONSEQ, 1'b1, 32'h00040010, 3'd2);
    @(negedge hclk);
    checks++; if (acc_wren !== 1'b0) begin failures++; $display("FAIL ww_wren_addr_phase: got %b want 0", acc_wren); end
    tick();
    p0_hwdata = 32'hCAFEF00D; p0_set(T_NONSEQ, 1'b1, 32'h00040011, 3'd0);
    @(negedge hclk);
    checks++; if (acc_wren !== 1'b1) begin failures++; $display("FAIL ww_wren: got %b want 1", acc_wren); end
    checks++; if (acc_addr !== 16'h0004) begin failures++; $display("FAIL ww_addr: got %h want 0004", acc_addr); end
    checks++; if (acc_wrbe !== 4'hF) begin failures++; $display("FAIL ww_wrbe: got %h want F", acc_wrbe); end
    checks++; if (acc_wrdata !== 32'hCAFEF00D) begin failures++; $display("FAIL ww_wrdata: got %h want CAFEF00D", acc_wrdata); end
    tick();
    p0_hwdata = 32'h00005A00; p0_set(T_IDLE, 1'b0, 32'h0, 3'd0);
    @(negedge hclk);
    checks++; if (acc_wren !== 1'b1) begin failures++; $display("FAIL ww_b2b_wren: got %b want 1", acc_wren); end
    checks++; if (acc_wrbe !== 4'h2) begin failures++; $display("FAIL ww_byte_wrbe: got %h want 2", acc_wrbe); end
    checks++; if (acc_addr !== 16'h0004) begin failures++; $display("FAIL ww_byte_addr: got %h want 0004", acc_addr); end
    tick();
    p0_set(T_NONSEQ, 1'b0, 32'h10, 3'd2);
    @(negedge hclk);
    checks++; if ({acc_wren, acc_wrbe} !== 5'b0) begin failures++; $display("FAIL ww_end: got %b want 00000", {acc_wren, acc_wrbe}); end
    tick();
    p0_set(T_IDLE, 1'b0, 32'h0, 3'd0);
    @(negedge hclk);
    checks++; if (p0_hrdata !== 32'h0A0B0C0D) begin failures++; $display("FAIL ww_mem_untouched: got %h want 0A0B0C0D", p0_hrdata); end
    tick();
  endtask

  task automatic test_window_read();
    acc_rddata = 32'h0; p0_set(T_NONSEQ, 1'b0, 32'h00040020, 3'd2);
    @(negedge hclk);
    checks++; if (acc_rden !== 1'b1) begin failures++; $display("FAIL wr_rden: got %b want 1", acc_rden); end
    checks++; if (acc_addr !== 16'h0008) begin failures++; $display("FAIL wr_addr: got %h want 0008", acc_addr); end
    checks++; if (d1_acc_rden !== 1'b1) begin failures++; $display("FAIL wr_d1_rden: got %b want 1", d1_acc_rden); end
    tick();
    acc_rddata = 32'h11111111; p0_set(T_NONSEQ, 1'b0, 32'h1000, 3'd2);
    @(negedge hclk);
    checks++; if (p0_hready !== 1'b0) begin failures++; $display("FAIL wr_wait1: got %b want 0", p0_hready); end
    checks++; if (acc_rden !== 1'b0) begin failures++; $display("FAIL wr_rden_in_wait: got %b want 0", acc_rden); end
    checks++; if (d1_p0_hready !== 1'b1) begin failures++; $display("FAIL wr_d1_hready: got %b want 1", d1_p0_hready); end
    checks++; if (d1_p0_hrdata !== 32'h11111111) begin failures++; $display("FAIL wr_d1_hrdata: got %h want 11111111", d1_p0_hrdata); end
    tick();
    p0_set(T_IDLE, 1'b0, 32'h0, 3'd0);
    @(negedge hclk);
    checks++; if (p0_hready !== 1'b0) begin failures++; $display("FAIL wr_wait2: got %b want 0", p0_hready); end
    checks++; if (d1_p0_hrdata !== 32'h55663344) begin failures++; $display("FAIL wr_d1_next_read: got %h want 55663344", d1_p0_hrdata); end
    tick();
    acc_rddata = 32'h3F800000;
    @(negedge hclk);
    checks++; if (p0_hready !== 1'b1) begin failures++; $display("FAIL wr_done_hready: got %b want 1", p0_hready); end
    checks++; if (p0_hrdata !== 32'h3F800000) begin failures++; $display("FAIL wr_done_hrdata: got %h want 3F800000", p0_hrdata); end
    tick();
    acc_rddata = 32'h0; p0_set(T_NONSEQ, 1'b0, 32'h1000, 3'd2); tick();
    p0_set(T_IDLE, 1'b0, 32'h0, 3'd0);
    @(negedge hclk);
    checks++; if (p0_hrdata !== 32'h55663344) begin failures++; $display("FAIL wr_then_sram: got %h want 55663344", p0_hrdata); end
    tick();
  endtask

  task automatic test_irq();
    acc_done = 1'b1; acc_irq_clr = 1'b1; tick();
    acc_done = 1'b0; acc_irq_clr = 1'b0;
    @(negedge hclk);
    checks++; if (acc_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins: got %b want 1", acc_irq); end
    tick();
    @(negedge hclk);
    checks++; if (acc_irq !== 1'b1) begin failures++; $display("FAIL irq_sticky: got %b want 1", acc_irq); end
    tick();
    acc_irq_clr = 1'b1; tick();
    acc_irq_clr = 1'b0;
    @(negedge hclk);
    checks++; if (acc_irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %b want 0", acc_irq); end
    tick();
  endtask

  task automatic test_reset_rwait();
    acc_rddata = 32'hBAD0BAD0; p0_set(T_NONSEQ, 1'b0, 32'h00040020, 3'd2); tick();
    p0_set(T_IDLE, 1'b0, 32'h0, 3'd0); hreset = 1'b1;
    @(negedge hclk);
    checks++; if (p0_hready !== 1'b0) begin failures++; $display("FAIL rr_in_wait: got %b want 0", p0_hready); end
    tick();
    hreset = 1'b0;
    @(negedge hclk);
    checks++; if (p0_hready !== 1'b1) begin failures++; $display("FAIL rr_hready: got %b want 1", p0_hready); end
    checks++; if (p0_hrdata !== 32'h0) begin failures++; $display("FAIL rr_hrdata: got %h want 0", p0_hrdata); end
    tick();
    @(negedge hclk);
    checks++; if ({p0_hready, p0_hrdata} !== {1'b1, 32'h0}) begin failures++; $display("FAIL rr_no_stale: got %b/%h want 1/0", p0_hready, p0_hrdata); end
    checks++; if (d1_p0_hrdata !== 32'h0) begin failures++; $display("FAIL rr_d1_hrdata: got %h want 0", d1_p0_hrdata); end
    tick();
    acc_rddata = 32'h0;
  endtask

  task automatic test_reset_wdata();
    p0_set(T_NONSEQ, 1'b1, 32'h1000, 3'd2); tick();
    p0_hwdata = 32'hFFFFFFFF; p0_set(T_IDLE, 1'b0, 32'h0, 3'd0); hreset = 1'b1;
    @(negedge hclk);
    checks++; if (acc_wren !== 1'b0) begin failures++; $display("FAIL rw_wren: got %b want 0", acc_wren); end
    tick();
    hreset = 1'b0; p0_set(T_NONSEQ, 1'b0, 32'h1000, 3'd2); tick();
    p0_set(T_IDLE, 1'b0, 32'h0, 3'd0);
    @(negedge hclk);
    checks++; if (p0_hrdata !== 32'h55663344) begin failures++; $display("FAIL rw_commit_dropped: got %h want 55663344", p0_hrdata); end
    tick();
  endtask

  initial begin
    hreset = 1'b1;
    p0_haddr = '0; p0_hwrite = 1'b0; p0_hsize = 3'd0; p0_hburst = 3'd0; p0_hmastlock = 1'b0;
    p0_hprot = 4'd0; p0_htrans = T_IDLE; p0_hwdata = '0;
    p1_haddr = '0; p1_hwrite = 1'b0; p1_hsize = 3'd2; p1_hburst = 3'd0; p1_hmastlock = 1'b0;
    p1_hprot = 4'd0; p1_htrans = T_IDLE; p1_hwdata = '0;
    acc_rddata = '0; acc_done = 1'b0; acc_irq_clr = 1'b0;

    test_reset();
    test_byte_write();
    test_bypass();
    test_window_write();
    test_window_read();
    test_irq();
    test_reset_rwait();
    test_reset_wdata();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
